// File: rtl/mips_multi_cycle.sv
// Multicycle MIPS subset core: one shared memory port, PC/IR/MDR/A/B/ALUOut, 32x32 register file.
// Latency: 3 to 5 cycles per instruction (IF, ID, then 1-3 class-specific states); halt is absorbing.
// Backpressure: none; memory is assumed zero-wait (combinational read, write on the closing edge).
module mips_multi_cycle (
  input  logic        rst,
  input  logic        clk,
  output logic [31:0] adrs,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        done
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_WB_R, S_EX_I, S_WB_I, S_MEM_ADR, S_MEM_RD,
    S_WB_LW, S_MEM_WR, S_BR, S_JMP, S_JAL, S_JR, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, ir, mdr, a_reg, b_reg, alu_out;
  logic [31:0] rf [32];

  // Instruction fields, always taken from the latched IR.
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, jmp_target;

  assign opcode     = ir[31:26];
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign funct      = ir[5:0];
  assign imm_ext    = {{16{ir[15]}}, ir[15:0]};
  // PC already holds the incremented value once IF has completed.
  assign jmp_target = {pc[31:28], ir[25:0], 2'b00};

  // Memory port: data accesses use ALUOut, everything else addresses by PC.
  assign adrs      = (state == S_MEM_RD || state == S_MEM_WR) ? alu_out : pc;
  assign mem_read  = (state == S_IF) || (state == S_MEM_RD);
  assign mem_write = (state == S_MEM_WR);
  assign done      = (state == S_HALT);
  assign data_out  = b_reg;

  // State register; reset aborts any instruction in flight and restarts at fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IF;
    else      state <= state_nxt;
  end

  // Next-state decode; unsupported opcodes/functs fall straight back to fetch.
  always_comb begin
    state_nxt = S_IF;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: state_nxt = S_EX_R;
              FN_JR:                                 state_nxt = S_JR;
              default:                               state_nxt = S_IF;
            endcase
          end
          OP_ADDI, OP_SLTI: state_nxt = S_EX_I;
          OP_LW, OP_SW:     state_nxt = S_MEM_ADR;
          OP_BEQ:           state_nxt = S_BR;
          OP_J:             state_nxt = S_JMP;
          OP_JAL:           state_nxt = S_JAL;
          OP_HALT:          state_nxt = S_HALT;
          default:          state_nxt = S_IF;
        endcase
      end
      S_EX_R:    state_nxt = S_WB_R;
      S_EX_I:    state_nxt = S_WB_I;
      S_MEM_ADR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  state_nxt = S_WB_LW;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_IF;
    endcase
  end

  // ALU: register/register in EX_R, register/immediate otherwise (EX_I, MEM_ADR).
  logic [31:0] alu_b, alu_res;
  always_comb begin
    alu_b   = (state == S_EX_R) ? b_reg : imm_ext;
    alu_res = a_reg + alu_b;
    if (state == S_EX_R) begin
      case (funct)
        FN_SUB:  alu_res = a_reg - alu_b;
        FN_AND:  alu_res = a_reg & alu_b;
        FN_OR:   alu_res = a_reg | alu_b;
        FN_SLT:  alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
        default: alu_res = a_reg + alu_b;
      endcase
    end else if (state == S_EX_I && opcode == OP_SLTI) begin
      alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
    end
  end

  // Register-file write port select: rd for R-type, rt for I-type/lw, $31 for jal.
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  always_comb begin
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = alu_out;
    case (state)
      S_WB_R:  begin rf_we = 1'b1; rf_wa = rd; end
      S_WB_I:  begin rf_we = 1'b1; rf_wa = rt; end
      S_WB_LW: begin rf_we = 1'b1; rf_wa = rt; rf_wd = mdr; end
      S_JAL:   begin rf_we = 1'b1; rf_wa = 5'd31; rf_wd = pc; end
      default: ;
    endcase
  end

  // Register file; $0 is never written so it reads as zero forever.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_wa != 5'd0) begin
      rf[rf_wa] <= rf_wd;
    end
  end

  // Datapath registers, each loaded only in the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        S_IF: begin
          ir <= data_in;
          pc <= pc + 32'd4;
        end
        S_ID: begin
          a_reg   <= rf[rs];
          b_reg   <= rf[rt];
          alu_out <= pc + {imm_ext[29:0], 2'b00};
        end
        S_EX_R, S_EX_I, S_MEM_ADR: alu_out <= alu_res;
        S_MEM_RD:                  mdr <= data_in;
        S_BR:                      if (a_reg == b_reg) pc <= alu_out;
        S_JMP, S_JAL:              pc <= jmp_target;
        S_JR:                      pc <= a_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi_cycle.sv
module tb_mips_multi_cycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adrs, data_in, data_out;
  logic        mem_read, mem_write, done;

  int checks = 0;
  int errors = 0;

  mips_multi_cycle dut (
    .rst(rst), .clk(clk), .adrs(adrs), .data_in(data_in), .data_out(data_out),
    .mem_read(mem_read), .mem_write(mem_write), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [31:0] HALT = 32'hFC00_0000;

  // Memory model: 4 KB, word indexed; program image copied in on load_req.
  logic [31:0] mem [0:1023];
  logic [31:0] img [0:1023];
  logic        load_req = 1'b0;
  int          wr_cnt = 0, rd_cnt = 0, cyc_ctr = 0, overlap_cnt = 0, halt_strobe_cnt = 0;
  logic [31:0] last_wr_adrs = '0, last_wr_data = '0;
  logic [31:0] rd_log [0:63];
  int          rd_cyc [0:63];

  assign data_in = mem[adrs[11:2]];

  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (load_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= img[i];
      wr_cnt <= 0;
      rd_cnt <= 0;
    end else begin
      if (mem_write) begin
        mem[adrs[11:2]] <= data_out;
        wr_cnt       <= wr_cnt + 1;
        last_wr_adrs <= adrs;
        last_wr_data <= data_out;
      end
      if (rst && mem_read && rd_cnt < 64) begin
        rd_log[rd_cnt] <= adrs;
        rd_cyc[rd_cnt] <= cyc_ctr;
        rd_cnt         <= rd_cnt + 1;
      end
      if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
      if (done && (mem_read || mem_write)) halt_strobe_cnt <= halt_strobe_cnt + 1;
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // ISA-level reference: executes the image instruction by instruction.
  logic [31:0] m_regs [0:31];
  logic [31:0] m_mem  [0:1023];

  task automatic model_run(output int cyc, output logic [31:0] fpc);
    logic [31:0] pc, pc4, ins, a, b, imm, ea;
    bit halted;
    for (int i = 0; i < 1024; i++) m_mem[i] = img[i];
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    pc = '0; cyc = 0; halted = 0; fpc = '0;
    for (int n = 0; n < 2000 && !halted; n++) begin
      ins = m_mem[pc[11:2]];
      pc4 = pc + 32'd4;
      a   = m_regs[ins[25:21]];
      b   = m_regs[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      ea  = a + imm;
      pc  = pc4;
      case (ins[31:26])
        6'h00: begin
          cyc += 4;
          case (ins[5:0])
            6'h20: m_regs[ins[15:11]] = a + b;
            6'h22: m_regs[ins[15:11]] = a - b;
            6'h24: m_regs[ins[15:11]] = a & b;
            6'h25: m_regs[ins[15:11]] = a | b;
            6'h2A: m_regs[ins[15:11]] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h08: begin pc = a; cyc -= 1; end
            default: cyc -= 1;
          endcase
        end
        6'h08: begin m_regs[ins[20:16]] = a + imm; cyc += 4; end
        6'h0A: begin m_regs[ins[20:16]] = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; cyc += 4; end
        6'h23: begin m_regs[ins[20:16]] = m_mem[ea[11:2]]; cyc += 5; end
        6'h2B: begin m_mem[ea[11:2]] = b; cyc += 4; end
        6'h04: begin if (a == b) pc = pc4 + (imm << 2); cyc += 3; end
        6'h02: begin pc = {pc4[31:28], ins[25:0], 2'b00}; cyc += 3; end
        6'h03: begin m_regs[31] = pc4; pc = {pc4[31:28], ins[25:0], 2'b00}; cyc += 3; end
        6'h3F: begin halted = 1; cyc += 2; fpc = pc4; end
        default: cyc += 3;
      endcase
      m_regs[0] = '0;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 1024; i++) img[i] = '0;
  endtask

  // Reset the core, load memory from img, release reset on a falling edge.
  task automatic start_prog();
    rst = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_done(output int cyc, output bit timed_out);
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    timed_out = (done !== 1'b1);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", dut.pc); end
    checks++; if (dut.ir !== 32'd0) begin errors++; $display("FAIL reset_ir: got %h want 0", dut.ir); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (adrs !== 32'd0 || mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_bus: adrs %h wr %b want 0/0", adrs, mem_write); end
  endtask

  task automatic test_basic();
    int cyc; bit to;
    clear_img();
    img[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    img[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    img[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
    img[3] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: done never rose"); end
    checks++; if (dut.rf[3] !== 32'd12) begin errors++; $display("FAIL basic_r3: got %h want 12", dut.rf[3]); end
    checks++; if (cyc != 14) begin errors++; $display("FAIL basic_cycles: got %0d want 14", cyc); end
    checks++; if (dut.pc !== 32'd16) begin errors++; $display("FAIL basic_pc: got %h want 10", dut.pc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || dut.pc !== 32'd16 || mem_read !== 1'b0) begin
      errors++; $display("FAIL basic_halt_hold: done %b pc %h rd %b want 1/10/0", done, dut.pc, mem_read); end
  endtask

  task automatic test_reset_after_run();
    int n0, nz;
    rst = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < 32; r++) if (dut.rf[r] !== 32'd0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL reset_rf: got %0d nonzero regs want 0", nz); end
    checks++; if (done !== 1'b0 || dut.pc !== 32'd0) begin
      errors++; $display("FAIL reset_async: done %b pc %h want 0/0", done, dut.pc); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dut.pc !== 32'd0) begin errors++; $display("FAIL reset_hold_pc: got %h want 0", dut.pc); end
    n0 = rd_cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rd_cnt != n0 + 1 || rd_log[n0] !== 32'd0) begin
      errors++; $display("FAIL reset_first_fetch: got %h want 0", rd_log[n0]); end
    checks++; if (dut.pc !== 32'd4) begin errors++; $display("FAIL reset_pc_inc: got %h want 4", dut.pc); end
  endtask

  task automatic test_mem();
    int cyc; bit to;
    clear_img();
    img[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    img[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd7);
    img[2] = enc_r(6'h20, 5'd1, 5'd2, 5'd3);
    img[3] = enc_i(OP_SW, 5'd0, 5'd3, 16'd100);
    img[4] = enc_i(OP_LW, 5'd0, 5'd4, 16'd100);
    img[5] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (to) begin errors++; $display("FAIL mem_timeout: done never rose"); end
    checks++; if (wr_cnt != 1) begin errors++; $display("FAIL mem_wr_count: got %0d want 1", wr_cnt); end
    checks++; if (last_wr_adrs !== 32'd100 || last_wr_data !== 32'd12) begin
      errors++; $display("FAIL mem_wr_bus: adrs %0d data %0d want 100/12", last_wr_adrs, last_wr_data); end
    checks++; if (dut.rf[4] !== 32'd12) begin errors++; $display("FAIL mem_lw_r4: got %h want 12", dut.rf[4]); end
    checks++; if (rd_log[5] !== 32'd100) begin errors++; $display("FAIL mem_rd_adrs: got %h want 100", rd_log[5]); end
    checks++; if (rd_cyc[6] - rd_cyc[4] != 5) begin
      errors++; $display("FAIL mem_lw_cycles: got %0d want 5", rd_cyc[6] - rd_cyc[4]); end
    checks++; if (cyc != 23) begin errors++; $display("FAIL mem_cycles: got %0d want 23", cyc); end
  endtask

  task automatic test_branch();
    int cyc; bit to;
    clear_img();
    img[0] = enc_i(OP_BEQ, 5'd1, 5'd1, 16'd2);
    img[1] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd1);
    img[2] = enc_i(OP_ADDI, 5'd0, 5'd6, 16'd1);
    img[3] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (rd_log[1] !== 32'd12) begin errors++; $display("FAIL beq_taken_fetch: got %h want c", rd_log[1]); end
    checks++; if (dut.rf[5] !== 32'd0 || dut.rf[6] !== 32'd0) begin
      errors++; $display("FAIL beq_taken_skip: r5 %h r6 %h want 0/0", dut.rf[5], dut.rf[6]); end
    checks++; if (to || cyc != 5) begin errors++; $display("FAIL beq_taken_cycles: got %0d want 5", cyc); end
    clear_img();
    img[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    img[1] = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd2);
    img[2] = enc_i(OP_ADDI, 5'd0, 5'd5, 16'd1);
    img[3] = enc_i(OP_ADDI, 5'd0, 5'd6, 16'd1);
    img[4] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (rd_log[2] !== 32'd8) begin errors++; $display("FAIL beq_not_fetch: got %h want 8", rd_log[2]); end
    checks++; if (dut.rf[5] !== 32'd1) begin errors++; $display("FAIL beq_not_r5: got %h want 1", dut.rf[5]); end
    checks++; if (to || cyc != 17) begin errors++; $display("FAIL beq_not_cycles: got %0d want 17", cyc); end
  endtask

  task automatic test_jump();
    int cyc; bit to;
    logic [31:0] exp_f [7];
    exp_f = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44, 32'hC, 32'h80};
    clear_img();
    img[0]  = enc_i(OP_ADDI, 5'd0, 5'd7, 16'd2);
    img[1]  = enc_i(OP_ADDI, 5'd0, 5'd8, 16'd3);
    img[2]  = enc_j(OP_JAL, 26'h10);
    img[3]  = enc_j(OP_J, 26'h20);
    img[16] = enc_i(OP_ADDI, 5'd0, 5'd9, 16'd4);
    img[17] = enc_r(6'h08, 5'd31, 5'd0, 5'd0);
    img[32] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (dut.rf[31] !== 32'd12) begin errors++; $display("FAIL jal_link: got %h want c", dut.rf[31]); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (rd_log[i] !== exp_f[i]) begin
        errors++; $display("FAIL jump_fetch_%0d: got %h want %h", i, rd_log[i], exp_f[i]); end
    end
    checks++; if (dut.rf[9] !== 32'd4) begin errors++; $display("FAIL jump_target_exec: got %h want 4", dut.rf[9]); end
    checks++; if (to || cyc != 23 || dut.pc !== 32'h84) begin
      errors++; $display("FAIL jump_cycles_pc: cyc %0d pc %h want 23/84", cyc, dut.pc); end
  endtask

  task automatic test_edge();
    int cyc; bit to;
    clear_img();
    img[64] = 32'h7FFF_FFFF;
    img[0]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFF);
    img[1]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
    img[2]  = enc_r(6'h2A, 5'd1, 5'd2, 5'd3);
    img[3]  = enc_r(6'h2A, 5'd2, 5'd1, 5'd4);
    img[4]  = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd9);
    img[5]  = enc_i(OP_LW, 5'd0, 5'd5, 16'h0100);
    img[6]  = enc_r(6'h20, 5'd5, 5'd2, 5'd6);
    img[7]  = enc_i(OP_SLTI, 5'd1, 5'd7, 16'd0);
    img[8]  = enc_r(6'h22, 5'd0, 5'd2, 5'd8);
    img[9]  = enc_r(6'h20, 5'd1, 5'd2, 5'd0);
    img[10] = HALT;
    start_prog();
    run_to_done(cyc, to);
    checks++; if (dut.rf[3] !== 32'd1) begin errors++; $display("FAIL slt_neg: got %h want 1", dut.rf[3]); end
    checks++; if (dut.rf[4] !== 32'd0) begin errors++; $display("FAIL slt_pos: got %h want 0", dut.rf[4]); end
    checks++; if (dut.rf[0] !== 32'd0) begin errors++; $display("FAIL r0_write: got %h want 0", dut.rf[0]); end
    checks++; if (dut.rf[6] !== 32'h8000_0000) begin errors++; $display("FAIL add_wrap: got %h want 80000000", dut.rf[6]); end
    checks++; if (dut.rf[7] !== 32'd1) begin errors++; $display("FAIL slti_neg: got %h want 1", dut.rf[7]); end
    checks++; if (dut.rf[8] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub_wrap: got %h want ffffffff", dut.rf[8]); end
    checks++; if (to || cyc != 43) begin errors++; $display("FAIL edge_cycles: got %0d want 43", cyc); end
  endtask

  task automatic test_reset_mid();
    clear_img();
    img[0]  = enc_i(OP_LW, 5'd0, 5'd4, 16'd100);
    img[1]  = HALT;
    img[25] = 32'hDEAD_BEEF;
    start_prog();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_read !== 1'b1 || adrs !== 32'd100) begin
      errors++; $display("FAIL mid_memrd: rd %b adrs %h want 1/64", mem_read, adrs); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dut.pc !== 32'd0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_abort: pc %h done %b want 0/0", dut.pc, done); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (dut.rf[4] !== 32'd0) begin errors++; $display("FAIL mid_no_wb: got %h want 0", dut.rf[4]); end
    clear_img();
    img[0] = enc_i(OP_SW, 5'd0, 5'd0, 16'd100);
    img[1] = HALT;
    start_prog();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", wr_cnt); end
  endtask

  task automatic test_random();
    int cyc, mcyc; bit to;
    logic [31:0] mpc;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fl [5];
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int p = 0; p < 8; p++) begin
      clear_img();
      for (int k = 0; k < 16; k++) img[128 + k] = $urandom;
      for (int i = 0; i < 14; i++) begin
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(1, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0, 1, 8, 9: img[i] = enc_i(OP_ADDI, rs, rt, imm);
          2:          img[i] = enc_i(OP_SLTI, rs, rt, imm);
          3, 4:       img[i] = enc_r(fl[$urandom_range(0, 4)], rs, rt, rd);
          5:          img[i] = enc_i(OP_LW, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 15)));
          6:          img[i] = enc_i(OP_SW, 5'd0, rt, 16'(32'h200 + 4 * $urandom_range(0, 15)));
          default:    img[i] = (i < 13) ? enc_i(OP_BEQ, rs, rt, 16'd1) : enc_i(OP_ADDI, rs, rt, imm);
        endcase
      end
      img[14] = HALT;
      model_run(mcyc, mpc);
      start_prog();
      run_to_done(cyc, to);
      checks++; if (to || cyc != mcyc) begin
        errors++; $display("FAIL rand%0d_cycles: got %0d want %0d", p, cyc, mcyc); end
      checks++; if (dut.pc !== mpc) begin errors++; $display("FAIL rand%0d_pc: got %h want %h", p, dut.pc, mpc); end
      for (int r = 1; r < 32; r++) begin
        checks++;
        if (dut.rf[r] !== m_regs[r]) begin
          errors++; $display("FAIL rand%0d_r%0d: got %h want %h", p, r, dut.rf[r], m_regs[r]); end
      end
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (mem[128 + k] !== m_mem[128 + k]) begin
          errors++; $display("FAIL rand%0d_mem%0d: got %h want %h", p, k, mem[128 + k], m_mem[128 + k]); end
      end
    end
  endtask

  task automatic test_bus_rules();
    checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); end
    checks++; if (halt_strobe_cnt != 0) begin errors++; $display("FAIL halt_strobes: got %0d cycles want 0", halt_strobe_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_after_run();
    test_mem();
    test_branch();
    test_jump();
    test_edge();
    test_reset_mid();
    test_random();
    test_bus_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
